// File: rtl/xiaobo_out_unpack.sv
// rtl/xiaobo_out_unpack.sv - FIFO-buffered unpacker of 64-bit filter results into 16-bit halfwords
//
// Buffers result words from the wavelet filter in a small FIFO. Each word is
// replayed to the host as four 16-bit halfwords, most significant first.
//
// Ports:
//   clk_50        system clock
//   reset_in      asynchronous active-low reset
//   in_data       64-bit result word from the filter
//   in_data_ready filter presents a word on in_data
//   in_take       registered accept; a push happens when in_take & in_data_ready
//   o_data        current halfword to the host
//   o_valid       o_data is valid
//   o_ready       host accepts o_data
//   o_last        o_data is the final halfword (bits [15:0]) of its word
//   fifo_level    occupied FIFO entries (the word in the holding register is not counted)
`timescale 1ns/1ps
module xiaobo_out_unpack #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_50,
  input  logic          reset_in,
  input  logic [63:0]   in_data,
  input  logic          in_data_ready,
  output logic          in_take,
  output logic [15:0]   o_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          o_last,
  output logic [LW-1:0] fifo_level
);

  localparam int PW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [LW-1:0] level;
  logic [LW-1:0] next_level;
  logic [63:0]   hold;
  logic [1:0]    lane;
  logic          valid_q;
  logic          take_q;
  logic          push;
  logic          pop;
  logic          accept;

  assign accept = valid_q & o_ready;

  // The full guard is redundant with take_q but keeps a push out of a full
  // FIFO even if a pop happens on the same edge.
  assign push = take_q & in_data_ready & (level != LW'(DEPTH));

  // Load a new word when nothing is shown, or when the last halfword of the
  // shown word is being accepted (back-to-back, no bubble).
  assign pop = (level != '0) & (~valid_q | (accept & (lane == 2'd3)));

  always_comb begin
    next_level = level + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk_50 or negedge reset_in) begin
    if (!reset_in) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      hold    <= '0;
      lane    <= '0;
      valid_q <= 1'b0;
      take_q  <= 1'b0;
    end else begin
      // in_take is registered from the next occupancy, so it drops on the
      // very edge the FIFO becomes full and has no input-to-output path.
      take_q <= (next_level != LW'(DEPTH));
      level  <= next_level;
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        hold    <= mem[rptr];
        rptr    <= rptr + PW'(1);
        lane    <= 2'd0;
        valid_q <= 1'b1;
      end else if (accept) begin
        if (lane == 2'd3) begin
          valid_q <= 1'b0;
          lane    <= 2'd0;
        end else begin
          lane <= lane + 2'd1;
        end
      end
    end
  end

  // Storage array carries no reset; occupancy is tracked by level alone.
  always_ff @(posedge clk_50) begin
    if (push) begin
      mem[wptr] <= in_data;
    end
  end

  always_comb begin
    o_data = 16'h0000;
    case (lane)
      2'd0: o_data = hold[63:48];
      2'd1: o_data = hold[47:32];
      2'd2: o_data = hold[31:16];
      2'd3: o_data = hold[15:0];
      default: o_data = 16'h0000;
    endcase
  end

  assign o_valid    = valid_q;
  assign o_last     = valid_q & (lane == 2'd3);
  assign in_take    = take_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_xiaobo_out_unpack.sv
// tb/tb_xiaobo_out_unpack.sv - self-checking bench for xiaobo_out_unpack
`timescale 1ns/1ps
module tb_xiaobo_out_unpack;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_50 = 1'b0;
  logic          reset_in;
  logic [63:0]   in_data;
  logic          in_data_ready;
  logic          in_take;
  logic [15:0]   o_data;
  logic          o_valid;
  logic          o_ready;
  logic          o_last;
  logic [LW-1:0] fifo_level;

  xiaobo_out_unpack #(.DEPTH(DEPTH)) dut (
    .clk_50        (clk_50),
    .reset_in      (reset_in),
    .in_data       (in_data),
    .in_data_ready (in_data_ready),
    .in_take       (in_take),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_ready       (o_ready),
    .o_last        (o_last),
    .fifo_level    (fifo_level)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } hw_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words offered by the source, halfwords owed to the host,
  // and the number of accepted words not yet fully delivered.
  logic [63:0] src_q [$];
  hw_t         hw_q  [$];
  hw_t         log_q [$];
  int          in_flight  = 0;
  int          pushed_now = 0;
  int          edges      = 0;
  int          n_push     = 0;
  int          hw_cnt     = 0;
  logic        stall      = 1'b0;
  logic [15:0] st_data    = '0;
  logic        st_last    = 1'b0;

  int   rmode   = 0;   // 0 ready, 1 stalled, 2 toggling, 3 random
  logic rand_in = 1'b0;
  logic manual  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus driver
  always @(negedge clk_50) begin
    case (rmode)
      0:       o_ready = 1'b1;
      1:       o_ready = 1'b0;
      2:       o_ready = ~o_ready;
      default: o_ready = 1'($urandom_range(0, 1));
    endcase
    if (!manual) begin
      if (src_q.size() > 0 && (!rand_in || $urandom_range(0, 3) != 0)) begin
        in_data_ready = 1'b1;
        in_data       = src_q[0];
      end else begin
        in_data_ready = 1'b0;
        in_data       = {$urandom, $urandom};
      end
    end
  end

  always @(negedge reset_in) begin
    hw_q.delete();
    src_q.delete();
    in_flight  = 0;
    pushed_now = 0;
    edges      = 0;
    stall      = 1'b0;
  end

  // Edge monitor: handshakes seen just before each rising edge
  always @(posedge clk_50) begin
    if (reset_in) begin
      pushed_now = 0;
      if (in_take && in_data_ready) begin
        for (int k = 3; k >= 0; k--) begin
          hw_t h;
          h.d = 16'((in_data >> (16 * k)) & 64'hFFFF);
          h.l = (k == 0);
          hw_q.push_back(h);
        end
        in_flight++;
        pushed_now = 1;
        n_push++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      if (o_valid && o_ready) begin
        if (hw_q.size() == 0) begin
          check_eq("spurious_hw", 64'(o_data), 64'hX);
        end else begin
          hw_t e;
          e = hw_q.pop_front();
          check_eq("hw_data", 64'(o_data), 64'(e.d));
          check_eq("hw_last", 64'(o_last), 64'(e.l));
          if (e.l) in_flight--;
        end
        log_q.push_back('{d: o_data, l: o_last});
        hw_cnt++;
      end
      stall   = o_valid && !o_ready;
      st_data = o_data;
      st_last = o_last;
      edges++;
    end
  end

  // State checker, away from the active edge
  always @(negedge clk_50) begin
    if (!reset_in) begin
      check_eq("rst_valid", 64'(o_valid), 0);
      check_eq("rst_take", 64'(in_take), 0);
      check_eq("rst_level", 64'(fifo_level), 0);
      check_eq("rst_data", 64'(o_data), 0);
      check_eq("rst_last", 64'(o_last), 0);
    end else begin
      int exp_valid;
      int exp_level;
      exp_valid = ((in_flight - pushed_now) > 0) ? 1 : 0;
      exp_level = in_flight - exp_valid;
      check_eq("valid", 64'(o_valid), 64'(exp_valid));
      check_eq("level", 64'(fifo_level), 64'(exp_level));
      check_eq("take", 64'(in_take), 64'((edges > 0) && (exp_level != DEPTH)));
      if (exp_valid != 0 && hw_q.size() > 0) begin
        check_eq("cur_data", 64'(o_data), 64'(hw_q[0].d));
        check_eq("cur_last", 64'(o_last), 64'(hw_q[0].l));
      end
      if (stall) begin
        check_eq("stall_data", 64'(o_data), 64'(st_data));
        check_eq("stall_last", 64'(o_last), 64'(st_last));
      end
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((src_q.size() != 0 || hw_q.size() != 0) && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    repeat (2) @(negedge clk_50);
    check_eq(tag, 64'(n < budget), 1);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] w6 [5];
    logic [15:0] exp1 [4];
    int acc0;

    exp1[0] = 16'h0123; exp1[1] = 16'h4567; exp1[2] = 16'h89AB; exp1[3] = 16'hCDEF;
    reset_in = 1'b0; in_data = '0; in_data_ready = 1'b0; o_ready = 1'b1;
    repeat (3) @(negedge clk_50);
    #2 reset_in = 1'b1;

    // Single word, host always ready
    log_q.delete();
    src_q.push_back(64'h0123_4567_89AB_CDEF);
    wait_idle(50, "t1_idle");
    check_eq("t1_count", 64'(log_q.size()), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      check_eq("t1_data", 64'(log_q[i].d), 64'(exp1[i]));
      check_eq("t1_last", 64'(log_q[i].l), 64'(i == 3));
    end
    check_eq("t1_valid_after", 64'(o_valid), 0);
    check_eq("t1_level_after", 64'(fifo_level), 0);

    // Host stalled; fill FIFO plus holding register, then release
    rmode = 1; log_q.delete(); n_push = 0;
    for (int i = 1; i <= 6; i++) src_q.push_back(64'(i));
    repeat (12) @(negedge clk_50);
    check_eq("t2_pushes", 64'(n_push), 5);
    check_eq("t2_take", 64'(in_take), 0);
    check_eq("t2_level", 64'(fifo_level), 4);
    check_eq("t2_hold", 64'(o_data), 0);
    check_eq("t2_valid", 64'(o_valid), 1);
    @(posedge clk_50); #1 rmode = 0;
    acc0 = hw_cnt;
    repeat (20) @(posedge clk_50);
    #1 check_eq("t2_nobubble", 64'(hw_cnt - acc0), 20);
    wait_idle(100, "t2_idle");
    check_eq("t2_count", 64'(log_q.size()), 24);
    if (log_q.size() >= 20) begin
      check_eq("t2_w5_hw3", 64'(log_q[19].d), 64'h0005);
      check_eq("t2_w5_last", 64'(log_q[19].l), 1);
    end

    // Toggling host ready
    rmode = 2; log_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back({$urandom, $urandom});
    wait_idle(300, "t3_idle");
    check_eq("t3_count", 64'(log_q.size()), 32);

    // Reset mid-word: lane 2 showing, two words queued
    rmode = 1;
    a = {$urandom, $urandom};
    src_q.push_back(a);
    src_q.push_back({$urandom, $urandom});
    src_q.push_back({$urandom, $urandom});
    repeat (8) @(negedge clk_50);
    check_eq("t4_level_pre", 64'(fifo_level), 2);
    @(posedge clk_50); #1 rmode = 0;
    repeat (2) @(posedge clk_50);
    #1 rmode = 1;
    @(negedge clk_50);
    check_eq("t4_lane2", 64'(o_data), 64'(a[31:16]));
    check_eq("t4_level2", 64'(fifo_level), 2);
    #3 reset_in = 1'b0;
    #1;
    check_eq("t4_async_valid", 64'(o_valid), 0);
    check_eq("t4_async_take", 64'(in_take), 0);
    check_eq("t4_async_level", 64'(fifo_level), 0);
    @(negedge clk_50);
    #2 reset_in = 1'b1;
    rmode = 0; log_q.delete();
    d = {$urandom, $urandom};
    src_q.push_back(d);
    wait_idle(50, "t4_idle");
    check_eq("t4_count", 64'(log_q.size()), 4);
    if (log_q.size() > 0) check_eq("t4_first", 64'(log_q[0].d), 64'(d[63:48]));

    // Continuous stream across pointer wrap
    log_q.delete(); n_push = 0;
    for (int i = 0; i < 3 * DEPTH + 1; i++) src_q.push_back({$urandom, $urandom});
    wait_idle(400, "t5_idle");
    check_eq("t5_words", 64'(n_push), 3 * DEPTH + 1);
    check_eq("t5_count", 64'(log_q.size()), 4 * (3 * DEPTH + 1));

    // Steady level 1: push lands on each last-halfword accept
    for (int i = 0; i < 5; i++) w6[i] = {$urandom, $urandom};
    manual = 1'b1;
    in_data_ready = 1'b1; in_data = w6[0];
    @(negedge clk_50); in_data = w6[1];
    @(negedge clk_50); in_data_ready = 1'b0;
    for (int k = 2; k < 5; k++) begin
      repeat (3) @(negedge clk_50);
      in_data_ready = 1'b1; in_data = w6[k];
      @(negedge clk_50);
      in_data_ready = 1'b0;
      check_eq("t6_level", 64'(fifo_level), 1);
      check_eq("t6_load", 64'(o_data), 64'(w6[k-1][63:48]));
    end
    manual = 1'b0;
    wait_idle(50, "t6_idle");

    // Random traffic on both sides
    rmode = 3; rand_in = 1'b1; log_q.delete();
    for (int i = 0; i < 40; i++) src_q.push_back({$urandom, $urandom});
    wait_idle(3000, "t7_idle");
    check_eq("t7_count", 64'(log_q.size()), 160);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
